// File: rtl/control_fsm.sv
// Multi-cycle controller for a small RV32 subset: sequences fetch, decode, execute, memory and writeback,
// drives the datapath control strobes, and counts retired instructions. Define CONTROL_FSM_HALT_EN to trap illegal opcodes in HALT.
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        mem_ready,
  output logic [3:0]  estado,
  output logic        alusrc,
  output logic        branch,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic [3:0]  alucontrol,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'b0000,
    DECODE  = 4'b0001,
    EXEC_R  = 4'b0010,
    MEMRD   = 4'b0011,
    MEMWR   = 4'b0100,
    MEMADDR = 4'b0101,
    BRANCH  = 4'b0110,
    WB      = 4'b0111,
    HALT    = 4'b1000,
    BRWAIT  = 4'b1001
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_e      state_q, state_d;
  logic        aluSrc_q, aluSrc_d;
  logic [3:0]  aluCtrl_q, aluCtrl_d;
  logic        isLoad_q, isLoad_d;
  logic [31:0] instret_q, instret_d;

  state_e      decTarget;
  logic        decLegal;
  logic        decAluSrc;
  logic [3:0]  decAluCtrl;
  logic        decIsLoad;
  logic        retire;

  // Instruction decode, consumed only while the FSM sits in DECODE.
  always_comb begin
    decTarget  = FETCH;
    decLegal   = 1'b1;
    decAluSrc  = 1'b0;
    decAluCtrl = 4'b0000;
    decIsLoad  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decTarget = EXEC_R;
        case (funct3)
          3'b000:  decAluCtrl = funct7_5 ? 4'b0110 : 4'b0010;
          3'b111:  decAluCtrl = 4'b0000;
          3'b110:  decAluCtrl = 4'b0001;
          3'b100:  decAluCtrl = 4'b0100;
          3'b101:  decAluCtrl = 4'b0101;
          default: decAluCtrl = 4'b0010;
        endcase
      end
      OP_ADDI: begin
        decTarget  = EXEC_R;
        decAluSrc  = 1'b1;
        decAluCtrl = 4'b0011;
      end
      OP_LW: begin
        decTarget  = MEMADDR;
        decAluSrc  = 1'b1;
        decAluCtrl = 4'b0010;
        decIsLoad  = 1'b1;
      end
      OP_SW: begin
        decTarget  = MEMADDR;
        decAluSrc  = 1'b1;
        decAluCtrl = 4'b0010;
      end
      OP_BEQ: begin
        decTarget  = BRANCH;
        decAluSrc  = 1'b1;
        decAluCtrl = 4'b0110;
      end
      default: decLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      aluSrc_q  <= 1'b0;
      aluCtrl_q <= 4'b0000;
      isLoad_q  <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      aluSrc_q  <= aluSrc_d;
      aluCtrl_q <= aluCtrl_d;
      isLoad_q  <= isLoad_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
`ifdef CONTROL_FSM_HALT_EN
      DECODE:  state_d = decLegal ? decTarget : HALT;
      HALT:    state_d = HALT;
`else
      DECODE:  state_d = decLegal ? decTarget : FETCH;
      HALT:    state_d = FETCH;
`endif
      EXEC_R:  state_d = WB;
      MEMADDR: state_d = isLoad_q ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = WB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      WB:      state_d = FETCH;
      BRANCH:  state_d = BRWAIT;
      BRWAIT:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // ALU setup is captured once in DECODE and held for the rest of the instruction.
  always_comb begin
    aluSrc_d  = aluSrc_q;
    aluCtrl_d = aluCtrl_q;
    isLoad_d  = isLoad_q;
    if (state_q == DECODE) begin
      aluSrc_d  = decAluSrc;
      aluCtrl_d = decAluCtrl;
      isLoad_d  = decIsLoad;
    end
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      WB:     retire = 1'b1;
      BRWAIT: retire = 1'b1;
      MEMWR:  retire = mem_ready;
`ifndef CONTROL_FSM_HALT_EN
      DECODE: retire = ~decLegal;
`endif
      default: retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // Strobes are gated by rst_n so nothing leaks out while reset is held in FETCH.
  always_comb begin
    branch   = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          memread = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        MEMRD:  memread = 1'b1;
        MEMWR:  memwrite = 1'b1;
        WB: begin
          regwrite = 1'b1;
          memtoreg = isLoad_q;
        end
        BRANCH: branch = 1'b1;
        BRWAIT: branch = 1'b1;
        default: ;
      endcase
    end
  end

  assign estado     = state_q;
  assign alusrc     = aluSrc_q;
  assign alucontrol = aluCtrl_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: walks each instruction class cycle by cycle
// against hand-derived state, strobe and ALU-setup tables, plus reset, illegal-opcode and counter-wrap cases.
module tb_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        mem_ready;
  logic [3:0]  estado;
  logic        alusrc, branch, irwrite, pcwrite, memread, memwrite, regwrite, memtoreg;
  logic [3:0]  alucontrol;
  logic [31:0] instret;

  logic [6:0]  ctl;
  logic [4:0]  alu;
  logic [31:0] expInstret;
  int          vectors;
  int          miscompares;

  assign ctl = {branch, irwrite, pcwrite, memread, memwrite, regwrite, memtoreg};
  assign alu = {alusrc, alucontrol};

  control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .mem_ready  (mem_ready),
    .estado     (estado),
    .alusrc     (alusrc),
    .branch     (branch),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alucontrol (alucontrol),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; mem_ready = 1'b1;
    expInstret = 32'd0;
    #12;
    vectors++;
    if ({estado, ctl, alu, instret} !== {4'h0, 7'h00, 5'h00, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset: got est=%h ctl=%h alu=%h ret=%h want all zero", estado, ctl, alu, instret);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, ctl} !== {4'h0, 7'h08}) begin
      miscompares++;
      $display("[TB] FAIL reset_fetch: got est=%h ctl=%h want est=0 ctl=08", estado, ctl);
    end
  endtask

  task automatic test_add();
    logic [3:0] expEst [4];
    logic [6:0] expCtl [4];
    expEst = '{4'h0, 4'h1, 4'h2, 4'h7};
    expCtl = '{7'h38, 7'h00, 7'h00, 7'h02};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
      #1;
      vectors++;
      if ({estado, ctl} !== {expEst[i], expCtl[i]}) begin
        miscompares++;
        $display("[TB] FAIL add c%0d: got est=%h ctl=%h want est=%h ctl=%h", i, estado, ctl, expEst[i], expCtl[i]);
      end
      if (i >= 2) begin
        vectors++;
        if (alu !== 5'b0_0010) begin
          miscompares++;
          $display("[TB] FAIL add_alu c%0d: got %b want 00010", i, alu);
        end
      end
    end
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, instret} !== {4'h0, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL add_retire: got est=%h ret=%h want est=0 ret=%h", estado, instret, expInstret);
    end
  endtask

  task automatic test_lw();
    logic       mr     [10];
    logic [3:0] expEst [10];
    logic [6:0] expCtl [10];
    mr     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    expEst = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h5, 4'h3, 4'h3, 4'h3, 4'h3, 4'h7};
    expCtl = '{7'h08, 7'h08, 7'h38, 7'h00, 7'h00, 7'h08, 7'h08, 7'h08, 7'h08, 7'h03};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = mr[i];
      #1;
      vectors++;
      if ({estado, ctl} !== {expEst[i], expCtl[i]}) begin
        miscompares++;
        $display("[TB] FAIL lw c%0d: got est=%h ctl=%h want est=%h ctl=%h", i, estado, ctl, expEst[i], expCtl[i]);
      end
      if (i >= 4) begin
        vectors++;
        if (alu !== 5'b1_0010) begin
          miscompares++;
          $display("[TB] FAIL lw_alu c%0d: got %b want 10010", i, alu);
        end
      end
    end
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, instret} !== {4'h0, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL lw_retire: got est=%h ret=%h want est=0 ret=%h", estado, instret, expInstret);
    end
  endtask

  // mem_ready stays high throughout, so FETCH and MEMWR must each take exactly one cycle.
  task automatic test_back_to_back();
    logic [3:0] expEst [4];
    logic [6:0] expCtl [4];
    expEst = '{4'h0, 4'h1, 4'h5, 4'h4};
    expCtl = '{7'h38, 7'h00, 7'h00, 7'h04};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b1;
      #1;
      vectors++;
      if ({estado, ctl} !== {expEst[i], expCtl[i]}) begin
        miscompares++;
        $display("[TB] FAIL sw c%0d: got est=%h ctl=%h want est=%h ctl=%h", i, estado, ctl, expEst[i], expCtl[i]);
      end
    end
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    #1;
    vectors++;
    if ({estado, ctl, instret} !== {4'h0, 7'h38, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL sw_retire: got est=%h ctl=%h ret=%h want est=0 ctl=38 ret=%h", estado, ctl, instret, expInstret);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_beq();
    logic [3:0] expEst [4];
    logic [6:0] expCtl [4];
    expEst = '{4'h0, 4'h1, 4'h6, 4'h9};
    expCtl = '{7'h38, 7'h00, 7'h40, 7'h40};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
      #1;
      vectors++;
      if ({estado, ctl} !== {expEst[i], expCtl[i]}) begin
        miscompares++;
        $display("[TB] FAIL beq c%0d: got est=%h ctl=%h want est=%h ctl=%h", i, estado, ctl, expEst[i], expCtl[i]);
      end
      if (i >= 2) begin
        vectors++;
        if (alu !== 5'b1_0110) begin
          miscompares++;
          $display("[TB] FAIL beq_alu c%0d: got %b want 10110", i, alu);
        end
      end
    end
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, instret} !== {4'h0, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL beq_retire: got est=%h ret=%h want est=0 ret=%h", estado, instret, expInstret);
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] op  [9];
    logic [2:0] f3  [9];
    logic       f7  [9];
    logic [4:0] exp [9];
    op  = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
            7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
    f3  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
    f7  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp = '{5'b0_0010, 5'b0_0110, 5'b0_0000, 5'b0_0001, 5'b0_0100,
            5'b0_0101, 5'b0_0010, 5'b0_0010, 5'b1_0011};
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        opcode = op[k]; funct3 = f3[k]; funct7_5 = f7[k]; mem_ready = 1'b1;
        #1;
        if (c == 0) begin
          vectors++;
          if ({estado, instret} !== {4'h0, expInstret}) begin
            miscompares++;
            $display("[TB] FAIL alu_fetch k%0d: got est=%h ret=%h want est=0 ret=%h", k, estado, instret, expInstret);
          end
        end
        if (c == 2) begin
          vectors++;
          if ({estado, alu} !== {4'h2, exp[k]}) begin
            miscompares++;
            $display("[TB] FAIL alu_exec k%0d: got est=%h alu=%b want est=2 alu=%b", k, estado, alu, exp[k]);
          end
        end
        if (c == 3) expInstret = expInstret + 32'd1;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (instret !== expInstret) begin
      miscompares++;
      $display("[TB] FAIL alu_retire: got %h want %h", instret, expInstret);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    opcode = 7'b1111111; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
    #1;
    vectors++;
    if ({estado, ctl} !== {4'h0, 7'h38}) begin
      miscompares++;
      $display("[TB] FAIL ill_fetch: got est=%h ctl=%h want est=0 ctl=38", estado, ctl);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, ctl} !== {4'h1, 7'h00}) begin
      miscompares++;
      $display("[TB] FAIL ill_decode: got est=%h ctl=%h want est=1 ctl=00", estado, ctl);
    end
`ifdef CONTROL_FSM_HALT_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      vectors++;
      if ({estado, ctl, alu, instret} !== {4'h8, 7'h00, 5'h00, expInstret}) begin
        miscompares++;
        $display("[TB] FAIL halt c%0d: got est=%h ctl=%h alu=%h ret=%h want est=8 ctl=00 alu=00 ret=%h",
                 i, estado, ctl, alu, instret, expInstret);
      end
    end
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    expInstret = 32'd0;
    vectors++;
    if ({estado, instret} !== {4'h0, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: got est=%h ret=%h want est=0 ret=0", estado, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
`else
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    #1;
    vectors++;
    if ({estado, ctl, instret} !== {4'h0, 7'h08, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL ill_nop: got est=%h ctl=%h ret=%h want est=0 ctl=08 ret=%h", estado, ctl, instret, expInstret);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] expEst [4];
    logic       mr     [4];
    expEst = '{4'h0, 4'h1, 4'h5, 4'h4};
    mr     = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = mr[i];
      #1;
      if (i == 3) begin
        vectors++;
        if ({estado, memwrite} !== {4'h4, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL rst_pre: got est=%h memwrite=%b want est=4 memwrite=1", estado, memwrite);
        end
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    expInstret = 32'd0;
    vectors++;
    if ({estado, ctl, alu, instret} !== {4'h0, 7'h00, 5'h00, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL rst_async: got est=%h ctl=%h alu=%h ret=%h want all zero", estado, ctl, alu, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({estado, ctl} !== {4'h0, 7'h08}) begin
      miscompares++;
      $display("[TB] FAIL rst_refetch: got est=%h ctl=%h want est=0 ctl=08", estado, ctl);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    vectors++;
    if ({estado, ctl} !== {4'h0, 7'h38}) begin
      miscompares++;
      $display("[TB] FAIL rst_fetch_done: got est=%h ctl=%h want est=0 ctl=38", estado, ctl);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (estado !== 4'h1) begin
      miscompares++;
      $display("[TB] FAIL rst_decode: got est=%h want 1", estado);
    end
    @(negedge clk);
    @(negedge clk);
    expInstret = expInstret + 32'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({estado, instret} !== {4'h0, expInstret}) begin
      miscompares++;
      $display("[TB] FAIL rst_sw_retire: got est=%h ret=%h want est=0 ret=%h", estado, instret, expInstret);
    end
  endtask

  // Four billion retires are out of reach, so the counter is deposited just below the wrap point.
  task automatic test_wrap();
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    expInstret = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (instret !== expInstret) begin
      miscompares++;
      $display("[TB] FAIL wrap_preload: got %h want %h", instret, expInstret);
    end
    test_add();
    vectors++;
    if (instret !== 32'h0000_0000) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero: got %h want 00000000", instret);
    end
    test_add();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_lw();
    test_back_to_back();
    test_beq();
    test_alu_decode();
    test_illegal();
    test_reset_mid_access();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
